// File: rtl/rip_mem_arbiter_pkg.sv
// Shared types for the RIP memory arbiter: requester select encoding and default starvation limit.
// The EXT select value exists only when RIP_MEM_ARB_EXT_EN is defined.
package rip_mem_arbiter_pkg;

  localparam int ARB_STARVE_LIMIT = 4;

`ifdef RIP_MEM_ARB_EXT_EN
  localparam int ARB_NREQ = 3;
`else
  localparam int ARB_NREQ = 2;
`endif

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF  = 0;
  localparam int GNT_MA  = 1;
  localparam int GNT_EXT = 2;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_IF   = 2'd1,
`ifdef RIP_MEM_ARB_EXT_EN
    ARB_EXT  = 2'd3,
`endif
    ARB_MA   = 2'd2
  } arb_sel_t;

endpackage

// File: rtl/rip_mem_arbiter_if.sv
// Requester and BRAM-side signal bundle; master = requesters + memory, slave = arbiter.
// EXT port signals exist only with RIP_MEM_ARB_EXT_EN.
interface rip_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  ma_req;
  logic [BE_WIDTH-1:0]   ma_we;
  logic [ADDR_WIDTH-1:0] ma_addr;
  logic [DATA_WIDTH-1:0] ma_din;
  logic                  ma_gnt;
  logic                  ma_rvalid;
  logic [DATA_WIDTH-1:0] ma_rdata;

`ifdef RIP_MEM_ARB_EXT_EN
  logic                  ext_req;
  logic [BE_WIDTH-1:0]   ext_we;
  logic [ADDR_WIDTH-1:0] ext_addr;
  logic [DATA_WIDTH-1:0] ext_din;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [DATA_WIDTH-1:0] ext_rdata;
`endif

  logic                  mem_en;
  logic [BE_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (
`ifdef RIP_MEM_ARB_EXT_EN
    output ext_req, ext_we, ext_addr, ext_din,
    input  ext_gnt, ext_rvalid, ext_rdata,
`endif
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ma_req, ma_we, ma_addr, ma_din,
    input  ma_gnt, ma_rvalid, ma_rdata,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout
  );

  modport slave (
`ifdef RIP_MEM_ARB_EXT_EN
    input  ext_req, ext_we, ext_addr, ext_din,
    output ext_gnt, ext_rvalid, ext_rdata,
`endif
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ma_req, ma_we, ma_addr, ma_din,
    output ma_gnt, ma_rvalid, ma_rdata,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout
  );

endinterface

// File: rtl/rip_mem_arb_pick.sv
// Combinational priority picker: starving IF > MA > EXT > IF; one-hot grant plus select code.
// Zero latency, no state; EXT leg present only with RIP_MEM_ARB_EXT_EN.
module rip_mem_arb_pick
  import rip_mem_arbiter_pkg::*;
(
  input  logic                if_req_i,
  input  logic                ma_req_i,
`ifdef RIP_MEM_ARB_EXT_EN
  input  logic                ext_req_i,
`endif
  input  logic                starve_i,
  output logic [ARB_NREQ-1:0] gnt_o,
  output arb_sel_t            sel_o
);

  always_comb begin
    gnt_o = '0;
    sel_o = ARB_NONE;
    if (starve_i && if_req_i) begin
      gnt_o[GNT_IF] = 1'b1;
      sel_o         = ARB_IF;
    end else if (ma_req_i) begin
      gnt_o[GNT_MA] = 1'b1;
      sel_o         = ARB_MA;
`ifdef RIP_MEM_ARB_EXT_EN
    end else if (ext_req_i) begin
      gnt_o[GNT_EXT] = 1'b1;
      sel_o          = ARB_EXT;
`endif
    end else if (if_req_i) begin
      gnt_o[GNT_IF] = 1'b1;
      sel_o         = ARB_IF;
    end
  end

endmodule

// File: rtl/rip_mem_arbiter.sv
// Single-port RIP memory arbiter: one grant per cycle, reads return one cycle after grant, IF starvation bounded.
// Requesters hold their request until gnt; EXT requester exists only with RIP_MEM_ARB_EXT_EN.
module rip_mem_arbiter
  import rip_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
)(
  input  logic                 clk,
  input  logic                 rstn,
  rip_mem_arbiter_if.slave     bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ARB_NREQ-1:0]   gnt;
  arb_sel_t              sel;
  arb_sel_t              rsp_sel_q, rsp_sel_d;
  logic [3:0]            starve_q, starve_d;
  logic                  starve;

  logic [BE_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  assign starve = (starve_q == 4'(STARVE_LIMIT));

  rip_mem_arb_pick u_pick (
    .if_req_i  (bus.if_req),
    .ma_req_i  (bus.ma_req),
`ifdef RIP_MEM_ARB_EXT_EN
    .ext_req_i (bus.ext_req),
`endif
    .starve_i  (starve),
    .gnt_o     (gnt),
    .sel_o     (sel)
  );

  assign bus.if_gnt = gnt[GNT_IF];
  assign bus.ma_gnt = gnt[GNT_MA];
`ifdef RIP_MEM_ARB_EXT_EN
  assign bus.ext_gnt = gnt[GNT_EXT];
`endif

  // Winner's access drives the BRAM port; a write clears the response slot so no rvalid follows.
  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_din   = '0;
    rsp_sel_d = ARB_NONE;
    case (sel)
      ARB_IF: begin
        mem_addr  = bus.if_addr;
        rsp_sel_d = ARB_IF;
      end
      ARB_MA: begin
        mem_we    = bus.ma_we;
        mem_addr  = bus.ma_addr;
        mem_din   = bus.ma_din;
        rsp_sel_d = (bus.ma_we == '0) ? ARB_MA : ARB_NONE;
      end
`ifdef RIP_MEM_ARB_EXT_EN
      ARB_EXT: begin
        mem_we    = bus.ext_we;
        mem_addr  = bus.ext_addr;
        mem_din   = bus.ext_din;
        rsp_sel_d = (bus.ext_we == '0) ? ARB_EXT : ARB_NONE;
      end
`endif
      default: ;
    endcase
  end

  assign bus.mem_en   = rstn && (gnt != '0);
  assign bus.mem_we   = mem_we;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_din  = mem_din;

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || bus.if_gnt) begin
      starve_d = 4'd0;
    end else if (!starve) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_sel_q <= ARB_NONE;
      starve_q  <= 4'd0;
    end else begin
      rsp_sel_q <= rsp_sel_d;
      starve_q  <= starve_d;
    end
  end

  assign bus.if_rvalid = (rsp_sel_q == ARB_IF);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_dout : '0;
  assign bus.ma_rvalid = (rsp_sel_q == ARB_MA);
  assign bus.ma_rdata  = bus.ma_rvalid ? bus.mem_dout : '0;
`ifdef RIP_MEM_ARB_EXT_EN
  assign bus.ext_rvalid = (rsp_sel_q == ARB_EXT);
  assign bus.ext_rdata  = bus.ext_rvalid ? bus.mem_dout : '0;
`endif

endmodule

// File: tb/tb_rip_mem_arbiter.sv
// Directed bench for rip_mem_arbiter with a 32-word byte-writable memory model behind the port.
// EXT scenarios compile in only with RIP_MEM_ARB_EXT_EN.
module tb_rip_mem_arbiter;

  logic clk = 1'b0;
  logic rstn;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rip_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  rip_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [31:0] mem [32];

  function automatic logic [31:0] init_word(input int i);
    case (i)
      16:      return 32'hDEAD_BEEF;
      3:       return 32'h1122_3344;
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  // Memory model: reloads its contents while reset is held, read-first on access.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr[4:0]][8*b +: 8] <= bus.mem_din[8*b +: 8];
      bus.mem_dout <= mem[bus.mem_addr[4:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.ma_req  = 1'b0;
    bus.ma_we   = '0;
    bus.ma_addr = '0;
    bus.ma_din  = '0;
`ifdef RIP_MEM_ARB_EXT_EN
    bus.ext_req  = 1'b0;
    bus.ext_we   = '0;
    bus.ext_addr = '0;
    bus.ext_din  = '0;
`endif
  endtask

  logic [9:0] exp_if_seq;
  logic [8:0] if_req_seq;
  logic [8:0] exp_if_seq2;
  logic       prev_if, prev_ma;

  initial begin
    rstn = 1'b0;
    idle_inputs();

    // Reset: grant follows inputs but memory is not enabled.
    bus.ma_req  = 1'b1;
    bus.ma_addr = 32'h2;
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_ma_gnt", bus.ma_gnt, 1);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_ma_rvalid", bus.ma_rvalid, 0);
    chk("rst_ma_rdata", bus.ma_rdata, 0);
    tick();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_ma_gnt", bus.ma_gnt, 1);
    chk("rel_mem_en", bus.mem_en, 1);
    chk("rel_mem_addr", bus.mem_addr, 32'h2);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rel_ma_rvalid", bus.ma_rvalid, 1);
    chk("rel_ma_rdata", bus.ma_rdata, 32'hA500_0002);
    chk("idle_mem_en", bus.mem_en, 0);
    chk("idle_mem_addr", bus.mem_addr, 0);
    chk("idle_gnt", {bus.if_gnt, bus.ma_gnt}, 0);

    // IF read routing.
    tick();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    @(negedge clk);
    chk("rd_if_gnt", bus.if_gnt, 1);
    chk("rd_mem_addr", bus.mem_addr, 32'h10);
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_if_rvalid_early", bus.if_rvalid, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rd_if_rvalid", bus.if_rvalid, 1);
    chk("rd_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    chk("rd_ma_rvalid", bus.ma_rvalid, 0);
    chk("rd_ma_rdata", bus.ma_rdata, 0);

    // Partial byte write, then read back the merged word.
    tick();
    bus.ma_req  = 1'b1;
    bus.ma_we   = 4'b0100;
    bus.ma_addr = 32'h3;
    bus.ma_din  = 32'h00AB_0000;
    @(negedge clk);
    chk("wr_ma_gnt", bus.ma_gnt, 1);
    chk("wr_mem_we", bus.mem_we, 4'b0100);
    chk("wr_mem_addr", bus.mem_addr, 32'h3);
    chk("wr_mem_din", bus.mem_din, 32'h00AB_0000);
    tick();
    bus.ma_we  = '0;
    bus.ma_din = '0;
    @(negedge clk);
    chk("wr_no_ma_rvalid", bus.ma_rvalid, 0);
    chk("wr_no_if_rvalid", bus.if_rvalid, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("wr_readback", bus.ma_rdata, 32'h11AB_3344);

    // MA and IF both held: forced IF win every fifth cycle.
    tick();
    exp_if_seq  = 10'b10_0001_0000;
    prev_if     = 1'b0;
    prev_ma     = 1'b0;
    bus.ma_req  = 1'b1;
    bus.ma_addr = 32'h5;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stv_if_gnt%0d", i), bus.if_gnt, exp_if_seq[i]);
      chk($sformatf("stv_ma_gnt%0d", i), bus.ma_gnt, !exp_if_seq[i]);
      chk($sformatf("stv_if_rv%0d", i), bus.if_rvalid, prev_if);
      chk($sformatf("stv_ma_rv%0d", i), bus.ma_rvalid, prev_ma);
      if (prev_if) chk($sformatf("stv_if_rd%0d", i), bus.if_rdata, 32'hA500_0006);
      prev_if = exp_if_seq[i];
      prev_ma = !exp_if_seq[i];
      tick();
    end

    // A cycle with if_req low restarts the starvation count.
    if_req_seq  = 9'b1_1111_0111;
    exp_if_seq2 = 9'b1_0000_0000;
    for (int i = 0; i < 9; i++) begin
      bus.if_req = if_req_seq[i];
      @(negedge clk);
      chk($sformatf("clr_if_gnt%0d", i), bus.if_gnt, exp_if_seq2[i]);
      tick();
    end
    idle_inputs();

    // Back-to-back reads from two requesters, each routed to its own port.
    tick();
    bus.ma_req  = 1'b1;
    bus.ma_addr = 32'h5;
    @(negedge clk);
    chk("b2b_ma_gnt", bus.ma_gnt, 1);
    tick();
    bus.ma_req = 1'b0;
`ifdef RIP_MEM_ARB_EXT_EN
    bus.ext_req  = 1'b1;
    bus.ext_addr = 32'h6;
    @(negedge clk);
    chk("b2b_ext_gnt", bus.ext_gnt, 1);
    chk("b2b_ma_rvalid", bus.ma_rvalid, 1);
    chk("b2b_ma_rdata", bus.ma_rdata, 32'hA500_0005);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("b2b_ext_rvalid", bus.ext_rvalid, 1);
    chk("b2b_ext_rdata", bus.ext_rdata, 32'hA500_0006);
    chk("b2b_ma_rvalid2", bus.ma_rvalid, 0);
`else
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h6;
    @(negedge clk);
    chk("b2b_if_gnt", bus.if_gnt, 1);
    chk("b2b_ma_rvalid", bus.ma_rvalid, 1);
    chk("b2b_ma_rdata", bus.ma_rdata, 32'hA500_0005);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("b2b_if_rvalid", bus.if_rvalid, 1);
    chk("b2b_if_rdata", bus.if_rdata, 32'hA500_0006);
    chk("b2b_ma_rvalid2", bus.ma_rvalid, 0);
`endif

    // Reset lands while an IF read response is pending.
    tick();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    @(negedge clk);
    chk("mid_if_gnt", bus.if_gnt, 1);
    tick();
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("mid_if_rvalid_rst", bus.if_rvalid, 0);
    chk("mid_if_rdata_rst", bus.if_rdata, 0);
    chk("mid_mem_en_rst", bus.mem_en, 0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_if_rvalid_rel", bus.if_rvalid, 0);
    tick();
    @(negedge clk);
    chk("mid_if_rvalid_rel2", bus.if_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
